// File: rtl/fft_reorder_buf_if.sv
// Sample stream bundle for fft_reorder_buf.
// Input side carries per-frame config; output side carries index/last.
interface fft_reorder_buf_if #(
    parameter int DATA_WID     = 16,
    parameter int LOG2_FFT_LEN = 6,
    parameter int STG_WID      = 3
);
    logic                    mode_i;
    logic [STG_WID-1:0]      stage_i;
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic [DATA_WID-1:0]     in_re_i;
    logic [DATA_WID-1:0]     in_im_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic [DATA_WID-1:0]     out_re_o;
    logic [DATA_WID-1:0]     out_im_o;
    logic                    out_last_o;
    logic [LOG2_FFT_LEN-1:0] out_idx_o;

    modport slave (
        input  mode_i, stage_i, in_valid_i,
        input  in_re_i, in_im_i, out_ready_i,
        output in_ready_o, out_valid_o, out_re_o,
        output out_im_o, out_last_o, out_idx_o
    );

    modport master (
        output mode_i, stage_i, in_valid_i,
        output in_re_i, in_im_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_re_o,
        input  out_im_o, out_last_o, out_idx_o
    );
endinterface

// File: rtl/fft_reorder_buf.sv
// Ping-pong frame buffer emitting natural or partial bit-reversed order.
// One bank loads while the other drains through a single output register.
module fft_reorder_buf #(
    parameter int FFT_LEN      = 64,
    parameter int LOG2_FFT_LEN = 6,
    parameter int DATA_WID     = 16,
    parameter int STG_WID      = 3
) (
    input logic              clk_i,
    input logic              rst_n_i,
    input logic              flush_i,
    fft_reorder_buf_if.slave io
);
    localparam int LG = LOG2_FFT_LEN;
    localparam int SW = 2 * DATA_WID;

    typedef logic [LG-1:0] cnt_t;
    typedef logic [STG_WID-1:0] stg_t;
    typedef enum logic {IDLE, STREAM} rd_st_t;

    logic [SW-1:0] mem [2][FFT_LEN];
    logic [1:0]    full;
    logic          wr_sel;
    logic          rd_sel;
    cnt_t          wr_cnt;
    cnt_t          rd_cnt;
    logic [1:0]    cfg_mode;
    stg_t          cfg_stage [2];
    rd_st_t        st;
    rd_st_t        st_nxt;
    logic          wr_acc;
    logic          wr_end;
    logic          can_ld;
    logic          ld;
    logic          rd_end;
    cnt_t          rd_addr;

    // Low K bits reversed, where K = LG - s; the full reverse
    // shifted right by s lands exactly those bits in place.
    function automatic cnt_t perm(input cnt_t k, input logic m,
                                  input stg_t s);
        cnt_t rev;
        stg_t kw;
        for (int i = 0; i < LG; i++)
            rev[i] = k[LG-1-i];
        kw = stg_t'(LG) - s;
        if (m && (s <= stg_t'(LG)) && (kw >= stg_t'(2)))
            perm = ((k >> kw) << kw) | (rev >> s);
        else
            perm = k;
    endfunction

    assign io.in_ready_o = rst_n_i & ~full[wr_sel];
    assign wr_acc  = io.in_valid_i & io.in_ready_o;
    assign wr_end  = wr_acc && (wr_cnt == cnt_t'(FFT_LEN - 1));
    assign rd_end  = (rd_cnt == cnt_t'(FFT_LEN - 1));
    assign rd_addr = perm(rd_cnt, cfg_mode[rd_sel], cfg_stage[rd_sel]);
    assign can_ld  = ~io.out_valid_o | io.out_ready_i;

    // Sample storage; contents are not cleared by reset.
    always_ff @(posedge clk_i) begin
        if (wr_acc && !flush_i)
            mem[wr_sel][wr_cnt] <= {io.in_re_i, io.in_im_i};
    end

    // Write pointer and per-bank config captured on a frame's first beat.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_cnt       <= '0;
            wr_sel       <= 1'b0;
            cfg_mode     <= '0;
            cfg_stage[0] <= '0;
            cfg_stage[1] <= '0;
        end else if (flush_i) begin
            wr_cnt       <= '0;
            wr_sel       <= 1'b0;
            cfg_mode     <= '0;
            cfg_stage[0] <= '0;
            cfg_stage[1] <= '0;
        end else if (wr_acc) begin
            if (wr_cnt == '0) begin
                cfg_mode[wr_sel]  <= io.mode_i;
                cfg_stage[wr_sel] <= io.stage_i;
            end
            wr_cnt <= wr_cnt + cnt_t'(1);
            if (wr_end)
                wr_sel <= ~wr_sel;
        end
    end

    // Bank-full flags: writer sets on frame end, reader clears after last load.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            full <= '0;
        end else if (flush_i) begin
            full <= '0;
        end else begin
            if (ld && rd_end)
                full[rd_sel] <= 1'b0;
            if (wr_end)
                full[wr_sel] <= 1'b1;
        end
    end

    // Output register and read pointer.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_cnt         <= '0;
            rd_sel         <= 1'b0;
            io.out_valid_o <= 1'b0;
            io.out_re_o    <= '0;
            io.out_im_o    <= '0;
            io.out_last_o  <= 1'b0;
            io.out_idx_o   <= '0;
        end else if (flush_i) begin
            rd_cnt         <= '0;
            rd_sel         <= 1'b0;
            io.out_valid_o <= 1'b0;
            io.out_re_o    <= '0;
            io.out_im_o    <= '0;
            io.out_last_o  <= 1'b0;
            io.out_idx_o   <= '0;
        end else if (ld) begin
            {io.out_re_o, io.out_im_o} <= mem[rd_sel][rd_addr];
            io.out_idx_o   <= rd_addr;
            io.out_last_o  <= rd_end;
            io.out_valid_o <= 1'b1;
            rd_cnt         <= rd_cnt + cnt_t'(1);
            if (rd_end)
                rd_sel <= ~rd_sel;
        end else if (io.out_ready_i) begin
            io.out_valid_o <= 1'b0;
        end
    end

    // Reader state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)
            st <= IDLE;
        else if (flush_i)
            st <= IDLE;
        else
            st <= st_nxt;
    end

    // Reader next state; chains into the other bank without a bubble.
    always_comb begin
        st_nxt = st;
        unique case (st)
            IDLE:
                if (ld)
                    st_nxt = STREAM;
            STREAM:
                if (ld && rd_end)
                    st_nxt = full[~rd_sel] ? STREAM : IDLE;
        endcase
    end

    // Reader load strobe; IDLE loads directly so latency stays one cycle.
    always_comb begin
        ld = 1'b0;
        unique case (st)
            IDLE:   ld = full[rd_sel] & can_ld;
            STREAM: ld = can_ld;
        endcase
    end
endmodule

// File: tb/tb_fft_reorder_buf.sv
// Bench for fft_reorder_buf: 8-point directed cases plus a 64-point
// run with random backpressure, checked against a frame-level model.
module tb_fft_reorder_buf;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int stalls = 0;

    always #5 clk = ~clk;

    // Free-running cycle count used for latency/bubble measurements.
    always @(posedge clk) cyc <= cyc + 1;

    fft_reorder_buf_if #(.DATA_WID(16), .LOG2_FFT_LEN(3), .STG_WID(3)) a8 ();
    fft_reorder_buf_if #(.DATA_WID(16), .LOG2_FFT_LEN(6), .STG_WID(3)) a64 ();

    fft_reorder_buf #(.FFT_LEN(8), .LOG2_FFT_LEN(3),
                      .DATA_WID(16), .STG_WID(3)) u8 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .io(a8));

    fft_reorder_buf #(.FFT_LEN(64), .LOG2_FFT_LEN(6),
                      .DATA_WID(16), .STG_WID(3)) u64 (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .io(a64));

    typedef struct {
        int id; int re; int im; int last; int idx;
    } beat_t;
    typedef struct {
        int id; int re; int last; int cyc;
    } log_t;

    beat_t mq[$];
    log_t  lg[$];
    int    fre [2][64];
    int    fim [2][64];
    int    fn [2];
    int    fmode [2];
    int    fstg [2];
    bit    hold [2];
    int    hre [2];
    int    him [2];
    int    hidx [2];
    int    hlast [2];

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    // Output position k reads index k with its low K bits mirrored.
    function automatic int exp_addr(input int k, input int l2,
                                    input int md, input int st);
        int kk, hi, lo, rev;
        kk = l2 - st;
        if (md == 0 || st > l2 || kk < 2)
            return k;
        hi = (k / (1 << kk)) * (1 << kk);
        lo = k % (1 << kk);
        rev = 0;
        for (int i = 0; i < kk; i++) begin
            rev = rev * 2 + (lo % 2);
            lo = lo / 2;
        end
        return hi + rev;
    endfunction

    task automatic mon(input int id, input int len, input int l2,
                       input bit clr, input bit iv, input bit ir,
                       input int ire, input int iim, input int imd,
                       input int ist, input bit ov, input bit ordy,
                       input int ore, input int oim, input int olast,
                       input int oidx);
        int f[$];
        beat_t b;
        int a;
        if (clr) begin
            mq = mq.find with (item.id != id);
            fn[id] = 0;
            hold[id] = 0;
            return;
        end
        if (iv && ir) begin
            if (fn[id] == 0) begin
                fmode[id] = imd;
                fstg[id] = ist;
            end
            fre[id][fn[id]] = ire;
            fim[id][fn[id]] = iim;
            fn[id]++;
            if (fn[id] == len) begin
                for (int k = 0; k < len; k++) begin
                    a = exp_addr(k, l2, fmode[id], fstg[id]);
                    b.id = id;
                    b.re = fre[id][a];
                    b.im = fim[id][a];
                    b.last = (k == len - 1) ? 1 : 0;
                    b.idx = a;
                    mq.push_back(b);
                end
                fn[id] = 0;
            end
        end
        if (ov && hold[id]) begin
            chk($sformatf("hold_re%0d", id), ore, hre[id]);
            chk($sformatf("hold_im%0d", id), oim, him[id]);
            chk($sformatf("hold_idx%0d", id), oidx, hidx[id]);
            chk($sformatf("hold_last%0d", id), olast, hlast[id]);
        end
        hold[id] = ov && !ordy;
        hre[id] = ore;
        him[id] = oim;
        hidx[id] = oidx;
        hlast[id] = olast;
        if (ov && ordy) begin
            f = mq.find_first_index with (item.id == id);
            if (f.size() == 0) begin
                chk($sformatf("extra_beat%0d", id), 1, 0);
            end else begin
                b = mq[f[0]];
                mq.delete(f[0]);
                chk($sformatf("re%0d", id), ore, b.re);
                chk($sformatf("im%0d", id), oim, b.im);
                chk($sformatf("last%0d", id), olast, b.last);
                chk($sformatf("idx%0d", id), oidx, b.idx);
                lg.push_back('{id, ore, olast, cyc});
            end
        end
    endtask

    // Model and compare for the 8-point instance.
    always @(negedge clk)
        mon(0, 8, 3, !rst_n || flush, a8.in_valid_i, a8.in_ready_o,
            int'($signed(a8.in_re_i)), int'($signed(a8.in_im_i)),
            int'(a8.mode_i), int'(a8.stage_i), a8.out_valid_o,
            a8.out_ready_i, int'($signed(a8.out_re_o)),
            int'($signed(a8.out_im_o)), int'(a8.out_last_o),
            int'(a8.out_idx_o));

    // Model and compare for the 64-point instance.
    always @(negedge clk)
        mon(1, 64, 6, !rst_n || flush, a64.in_valid_i, a64.in_ready_o,
            int'($signed(a64.in_re_i)), int'($signed(a64.in_im_i)),
            int'(a64.mode_i), int'(a64.stage_i), a64.out_valid_o,
            a64.out_ready_i, int'($signed(a64.out_re_o)),
            int'($signed(a64.out_im_o)), int'(a64.out_last_o),
            int'(a64.out_idx_o));

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int id, input bit v, input int re,
                          input int md, input int st);
        if (id == 0) begin
            a8.in_valid_i = v;
            a8.in_re_i = 16'(re);
            a8.in_im_i = 16'(-re);
            a8.mode_i = md[0];
            a8.stage_i = 3'(st);
        end else begin
            a64.in_valid_i = v;
            a64.in_re_i = 16'(re);
            a64.in_im_i = 16'(-re);
            a64.mode_i = md[0];
            a64.stage_i = 3'(st);
        end
    endtask

    // Config is only valid on beat 0; later beats carry junk config.
    task automatic send(input int id, input int len, input int tag,
                        input int md, input int st, input int nb);
        bit r;
        bit acc;
        for (int n = 0; n < nb; n++) begin
            if (n == 0)
                set_in(id, 1, tag * len + n, md, st);
            else
                set_in(id, 1, tag * len + n, md ^ 1, st + n);
            acc = 0;
            for (int t = 0; t < 500 && !acc; t++) begin
                @(negedge clk);
                r = (id == 0) ? a8.in_ready_o : a64.in_ready_o;
                if (!r)
                    stalls++;
                @(posedge clk);
                #1;
                acc = r;
            end
            if (!acc)
                chk("send_timeout", 0, 1);
        end
        set_in(id, 0, 0, 0, 0);
    endtask

    task automatic wait_idle(input int id);
        int f[$];
        bit done;
        bit ov;
        done = 0;
        for (int t = 0; t < 3000 && !done; t++) begin
            @(negedge clk);
            #2;
            f = mq.find_first_index with (item.id == id);
            ov = (id == 0) ? a8.out_valid_o : a64.out_valid_o;
            done = (f.size() == 0) && !ov && (fn[id] == 0);
        end
        if (!done)
            chk("drain_timeout", 0, 1);
    endtask

    task automatic wait_log(input int n);
        bit done;
        done = 0;
        for (int t = 0; t < 500 && !done; t++) begin
            @(negedge clk);
            #2;
            done = (lg.size() >= n);
        end
        if (!done)
            chk("log_timeout", 0, 1);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_valid"}, int'(a8.out_valid_o), 0);
        chk({nm, "_re"}, int'(a8.out_re_o), 0);
        chk({nm, "_im"}, int'(a8.out_im_o), 0);
        chk({nm, "_last"}, int'(a8.out_last_o), 0);
        chk({nm, "_idx"}, int'(a8.out_idx_o), 0);
    endtask

    task automatic chk_frame8(input string nm, input int tag, input int md,
                              input int st, input int ex[8]);
        lg.delete();
        step(1);
        send(0, 8, tag, md, st, 8);
        wait_idle(0);
        chk({nm, "_n"}, lg.size(), 8);
        for (int k = 0; k < 8 && k < lg.size(); k++)
            chk($sformatf("%s_b%0d", nm, k), lg[k].re, tag * 8 + ex[k]);
        if (lg.size() == 8)
            chk({nm, "_lastb"}, lg[7].last, 1);
    endtask

    initial begin
        int rev8[8];
        int st1[8];
        int ident[8];
        int c0;
        int cv;
        bit done6;
        rev8 = '{0, 4, 2, 6, 1, 5, 3, 7};
        st1 = '{0, 2, 1, 3, 4, 6, 5, 7};
        ident = '{0, 1, 2, 3, 4, 5, 6, 7};
        set_in(0, 0, 0, 0, 0);
        set_in(1, 0, 0, 0, 0);
        a8.out_ready_i = 1'b1;
        a64.out_ready_i = 1'b1;
        rst_n = 1'b0;
        step(2);
        chk("rst_rdy", int'(a8.in_ready_o), 0);
        chk_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_rdy", int'(a8.in_ready_o), 1);

        step(1);
        lg.delete();
        c0 = cyc;
        cv = 0;
        fork
            send(0, 8, 0, 1, 0, 8);
            begin
                for (int t = 0; t < 40 && cv == 0; t++) begin
                    @(negedge clk);
                    if (a8.out_valid_o)
                        cv = cyc;
                end
            end
        join
        chk("t1_latency", cv - c0, 9);
        wait_idle(0);
        chk("t1_n", lg.size(), 8);
        for (int k = 0; k < 8 && k < lg.size(); k++)
            chk($sformatf("t1_b%0d", k), lg[k].re, rev8[k]);
        if (lg.size() == 8) begin
            chk("t1_last7", lg[7].last, 1);
            chk("t1_last6", lg[6].last, 0);
        end

        chk_frame8("t2_st1", 1, 1, 1, st1);
        chk_frame8("t2_nat", 2, 0, 0, ident);
        chk_frame8("t2_st2", 3, 1, 2, ident);
        chk_frame8("t2_st5", 4, 1, 5, ident);

        lg.delete();
        stalls = 0;
        step(1);
        send(0, 8, 1, 1, 0, 8);
        send(0, 8, 2, 1, 0, 8);
        send(0, 8, 3, 0, 0, 8);
        wait_idle(0);
        chk("t3_stalls", stalls, 0);
        chk("t3_n", lg.size(), 24);
        if (lg.size() == 24) begin
            chk("t3_span", lg[23].cyc - lg[0].cyc, 23);
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("t3_f0b%0d", k), lg[k].re, 8 + rev8[k]);
                chk($sformatf("t3_f1b%0d", k), lg[8 + k].re, 16 + rev8[k]);
                chk($sformatf("t3_f2b%0d", k), lg[16 + k].re, 24 + k);
            end
        end

        a8.out_ready_i = 1'b0;
        lg.delete();
        step(1);
        send(0, 8, 4, 1, 1, 8);
        send(0, 8, 5, 1, 1, 8);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_rdy", int'(a8.in_ready_o), 0);
            chk("t4_valid", int'(a8.out_valid_o), 1);
            chk("t4_re", int'(a8.out_re_o), 32);
        end
        step(1);
        a8.out_ready_i = 1'b1;
        send(0, 8, 6, 0, 0, 8);
        wait_idle(0);
        chk("t4_n", lg.size(), 24);
        if (lg.size() == 24) begin
            chk("t4_b1", lg[1].re, 34);
            chk("t4_b10", lg[10].re, 41);
            chk("t4_b21", lg[21].re, 53);
        end

        lg.delete();
        step(1);
        send(0, 8, 1, 1, 0, 5);
        set_in(0, 1, 13, 1, 0);
        rst_n = 1'b0;
        #1;
        chk("t5a_rdy", int'(a8.in_ready_o), 0);
        chk_zero("t5a");
        set_in(0, 0, 0, 0, 0);
        step(1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5a_rel", int'(a8.in_ready_o), 1);
        chk_frame8("t5a_fr", 2, 1, 0, rev8);

        lg.delete();
        step(1);
        send(0, 8, 3, 1, 0, 8);
        wait_log(3);
        step(1);
        rst_n = 1'b0;
        #1;
        chk_zero("t5b");
        step(1);
        rst_n = 1'b1;
        chk_frame8("t5b_fr", 4, 1, 1, st1);

        lg.delete();
        step(1);
        send(0, 8, 5, 1, 0, 8);
        wait_log(2);
        step(1);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        chk_zero("t5c");
        chk_frame8("t5c_fr", 6, 1, 0, rev8);

        lg.delete();
        done6 = 0;
        step(1);
        fork
            begin
                send(1, 64, 0, 1, 0, 64);
                send(1, 64, 1, 1, 0, 64);
                wait_idle(1);
                done6 = 1;
            end
            begin
                while (!done6) begin
                    @(posedge clk);
                    #1;
                    a64.out_ready_i = 1'($urandom_range(0, 1));
                end
            end
        join
        a64.out_ready_i = 1'b1;
        chk("t6_n", lg.size(), 128);
        if (lg.size() == 128) begin
            chk("t6_b1", lg[1].re, 32);
            chk("t6_b6", lg[6].re, 24);
            chk("t6_b63", lg[63].re, 63);
            chk("t6_last63", lg[63].last, 1);
            chk("t6_b65", lg[65].re, 96);
            chk("t6_b127", lg[127].re, 127);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound.
    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
